// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD 7-segment scanner: FSM states and active-low
// segment patterns ordered {g,f,e,d,c,b,a}.
package bcd_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      GUARD = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational 4-bit BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_7seg
   import bcd_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner with per-frame BCD snapshot and guard gaps.
// Define BCD_DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int NUMBCDS   = 4,
   parameter int CLK_DIV   = 50000,
   parameter int GUARD_CYC = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUMBCDS*4-1:0] bcd,
   output logic [6:0]           seg,
   output logic [NUMBCDS-1:0]   an,
   output logic                 frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam int DW = (NUMBCDS > 1) ? $clog2(NUMBCDS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GRD_LAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
   localparam logic [DW-1:0] DIG_LAST = DW'(NUMBCDS - 1);

   state_t               state, state_n;
   logic [DW-1:0]        digit, digit_n;
   logic [NUMBCDS*4-1:0] shadow, shadow_n;
   logic [PW-1:0]        pre, pre_n;
   logic [GW-1:0]        grd, grd_n;
   logic                 wrap, adv;
   logic [3:0]           nib;
   logic [6:0]           dec, seg_n;
   logic [NUMBCDS-1:0]   an_n, blank_n;
`ifdef BCD_DISPLAY_SCAN_LZB_EN
   logic                 lead_zero;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         digit      <= '0;
         shadow     <= '0;
         pre        <= '0;
         grd        <= '0;
         seg        <= SEG_OFF;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         digit      <= digit_n;
         shadow     <= shadow_n;
         pre        <= pre_n;
         grd        <= grd_n;
         seg        <= seg_n;
         an         <= an_n;
         frame_done <= wrap;
      end
   end

   always_comb begin
      state_n  = state;
      digit_n  = digit;
      shadow_n = shadow;
      pre_n    = pre;
      grd_n    = grd;
      wrap     = 1'b0;
      adv      = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         digit_n = '0;
         pre_n   = '0;
         grd_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n  = SHOW;
               digit_n  = '0;
               shadow_n = bcd;
               pre_n    = '0;
            end
            SHOW: begin
               if (pre == PRE_LAST) begin
                  pre_n = '0;
                  if (GUARD_CYC == 0) begin
                     adv = 1'b1;
                  end else begin
                     state_n = GUARD;
                     grd_n   = '0;
                  end
               end else begin
                  pre_n = pre + 1'b1;
               end
            end
            GUARD: begin
               if (grd == GRD_LAST) begin
                  grd_n = '0;
                  adv   = 1'b1;
               end else begin
                  grd_n = grd + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
         // Wrap to digit 0 reloads the snapshot so a frame never mixes two values.
         if (adv) begin
            state_n = SHOW;
            if (digit == DIG_LAST) begin
               digit_n  = '0;
               shadow_n = bcd;
               wrap     = 1'b1;
            end else begin
               digit_n = digit + 1'b1;
            end
         end
      end
   end

   // Outputs are decoded from next-state values so seg and an are registered together.
   assign nib = shadow_n[{digit_n, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .digit (nib),
      .seg   (dec)
   );

   always_comb begin
      blank_n = '0;
`ifdef BCD_DISPLAY_SCAN_LZB_EN
      lead_zero = 1'b1;
      for (int unsigned k = NUMBCDS - 1; k > 0; k--) begin
         lead_zero  = lead_zero && (shadow_n[4*k +: 4] == 4'd0);
         blank_n[k] = lead_zero;
      end
`endif
   end

   always_comb begin
      an_n  = '1;
      seg_n = SEG_OFF;
      if (state_n == SHOW && !blank_n[digit_n]) begin
         an_n[digit_n] = 1'b0;
         seg_n         = dec;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (NUMBCDS=4, CLK_DIV=4, GUARD_CYC=1);
// honours BCD_DISPLAY_SCAN_LZB_EN when building expectations.
module tb_bcd_display_scan;

   logic        clk    = 1'b0;
   logic        rst    = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] bcd    = 16'h0000;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       seg_care;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bcd_display_scan #(
      .NUMBCDS   (4),
      .CLK_DIV   (4),
      .GUARD_CYC (1)
   ) dut (
      .clock      (clk),
      .reset      (rst),
      .enable     (enable),
      .bcd        (bcd),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic void push(input logic [3:0] a, input logic [6:0] s,
                                input logic c, input logic f);
      exp_t e;
      e.an = a;
      e.seg = s;
      e.seg_care = c;
      e.fd = f;
      exp_q.push_back(e);
   endfunction

   task automatic tick(input string tag);
      exp_t e;
      @(negedge clk);
      check_eq({tag, ".sb"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq({tag, ".an"}, 32'(an), 32'(e.an));
         if (e.seg_care) check_eq({tag, ".seg"}, 32'(seg), 32'(e.seg));
         check_eq({tag, ".fd"}, 32'(frame_done), 32'(e.fd));
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         push(4'hF, 7'h7F, 1'b1, 1'b0);
         tick(tag);
      end
   endtask

   // Frame = 4 digits x (4 lit cycles + 1 guard); only slots [from,upto) are run.
   task automatic run_frame(input logic [15:0] val, input bit first,
                            input int from, input int upto, input string tag);
      int idx;
      idx = 0;
      for (int d = 0; d < 4; d++) begin
         logic [3:0] nib;
         logic [3:0] onehot;
         bit         blank;
         nib    = val[4*d +: 4];
         onehot = 4'b0001 << d;
         blank  = 1'b0;
`ifdef BCD_DISPLAY_SCAN_LZB_EN
         blank = (d > 0) && ((val >> (4*d)) == 16'h0000);
`endif
         for (int c = 0; c < 5; c++) begin
            if (idx >= from && idx < upto) begin
               if (c == 4)     push(4'hF, 7'h7F, 1'b0, 1'b0);
               else if (blank) push(4'hF, 7'h7F, 1'b0, 1'b0);
               else            push(~onehot, seg_of(nib), 1'b1,
                                    (d == 0 && c == 0 && !first));
            end
            idx++;
         end
      end
      for (int i = from; i < upto; i++) tick(tag);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      check_eq("rst.an", 32'(an), 32'hF);
      check_eq("rst.seg", 32'(seg), 32'h7F);
      check_eq("rst.fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(20, "idle");

      bcd = 16'h1234;
      enable = 1'b1;
      run_frame(16'h1234, 1'b1, 0, 20, "f1");
      run_frame(16'h1234, 1'b0, 0, 11, "f2a");
      bcd = 16'h5678;
      run_frame(16'h1234, 1'b0, 11, 20, "f2b");
      run_frame(16'h5678, 1'b0, 0, 20, "f3");
      bcd = 16'h00A7;
      run_frame(16'h00A7, 1'b0, 0, 20, "f4");
      bcd = 16'h0000;
      run_frame(16'h0000, 1'b0, 0, 20, "f5");
      bcd = 16'h1234;
      run_frame(16'h1234, 1'b0, 0, 5, "f6");

      enable = 1'b0;
      bcd = 16'h4321;
      idle_cycles(3, "dis");
      enable = 1'b1;
      run_frame(16'h4321, 1'b1, 0, 20, "re1");
      run_frame(16'h4321, 1'b0, 0, 7, "re2");

      #2 rst = 1'b1;
      #1;
      check_eq("arst.an", 32'(an), 32'hF);
      check_eq("arst.seg", 32'(seg), 32'h7F);
      check_eq("arst.fd", 32'(frame_done), 32'h0);
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bcd = 16'h9080;
      idle_cycles(3, "post");
      enable = 1'b1;
      run_frame(16'h9080, 1'b1, 0, 20, "g1");
      run_frame(16'h9080, 1'b0, 0, 1, "g2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
